// File: rtl/iterative_divider_ctrl_pkg.sv
// Shared types and widths for the iterative restoring divider.
package iterative_divider_ctrl_pkg;

  localparam int unsigned DIV_DATA_WIDTH = 32;
  localparam int unsigned DIV_CNT_WIDTH  = $clog2(DIV_DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIXUP,
    S_DONE
  } state_divider_e;

  typedef struct packed {
    logic                      start;
    logic                      is_signed;
    logic [DIV_DATA_WIDTH-1:0] num;
    logic [DIV_DATA_WIDTH-1:0] denom;
  } port_in_divider_t;

  typedef struct packed {
    logic                      busy;
    logic                      done;
    logic [DIV_DATA_WIDTH-1:0] quot;
    logic [DIV_DATA_WIDTH-1:0] rem;
    logic                      div_by_zero;
  } port_out_divider_t;

endpackage

// File: rtl/iterative_divider_ctrl_divider_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module iterative_divider_ctrl_divider_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] r_i,
  input  logic         nmsb_i,
  input  logic [W-1:0] denom_i,
  output logic [W-1:0] r_next_o,
  output logic         q_bit_o
);

  logic [W-1:0] rs_c;
  logic [W:0]   diff_c;
  logic         ltu_c;

  assign rs_c   = {r_i[W-2:0], nmsb_i};
  // Compare: borrow out of a W+1 bit subtraction.
  assign diff_c = {1'b0, rs_c} - {1'b0, denom_i};
  // The bit shifted out of R is the implicit MSB of Rs; when set, Rs exceeds any divisor.
  assign ltu_c  = ~r_i[W-1] & diff_c[W];

  // Subtractor result is taken modulo 2^W.
  assign r_next_o = ltu_c ? rs_c : diff_c[W-1:0];
  assign q_bit_o  = ~ltu_c;

endmodule

// File: rtl/iterative_divider_ctrl.sv
// Multi-cycle restoring integer divider controller: one quotient bit per cycle,
// signed/unsigned operands, divide-by-zero handling, registered outputs.
module iterative_divider_ctrl
  import iterative_divider_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_start,
  input  logic                  in_signed,
  input  logic [DATA_WIDTH-1:0] in_num,
  input  logic [DATA_WIDTH-1:0] in_denom,
  output logic                  out_busy,
  output logic                  out_done,
  output logic [DATA_WIDTH-1:0] out_quot,
  output logic [DATA_WIDTH-1:0] out_rem,
  output logic                  out_div_by_zero
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  state_divider_e        state_q;
  logic [DATA_WIDTH-1:0] n_q, d_q, r_q, q_q, num_q;
  logic [DATA_WIDTH-1:0] quot_q, rem_q;
  logic                  neg_quot_q, neg_rem_q, zero_q;
  logic                  busy_q, done_q, dbz_q;
  logic [CntW-1:0]       cnt_q;

  logic [DATA_WIDTH-1:0] num_mag_c, den_mag_c, step_r_c;
  logic                  step_bit_c;

  assign num_mag_c = (in_signed && in_num[DATA_WIDTH-1])   ? -in_num   : in_num;
  assign den_mag_c = (in_signed && in_denom[DATA_WIDTH-1]) ? -in_denom : in_denom;

  iterative_divider_ctrl_divider_step #(.W(DATA_WIDTH)) u_step (
    .r_i      (r_q),
    .nmsb_i   (n_q[DATA_WIDTH-1]),
    .denom_i  (d_q),
    .r_next_o (step_r_c),
    .q_bit_o  (step_bit_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      q_q        <= '0;
      num_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_start) begin
            n_q        <= num_mag_c;
            d_q        <= den_mag_c;
            num_q      <= in_num;
            neg_quot_q <= in_signed & (in_num[DATA_WIDTH-1] ^ in_denom[DATA_WIDTH-1]);
            neg_rem_q  <= in_signed & in_num[DATA_WIDTH-1];
            zero_q     <= (in_denom == '0);
            r_q        <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= (in_denom == '0) ? S_FIXUP : S_ITER;
          end
        end
        S_ITER: begin
          n_q   <= {n_q[DATA_WIDTH-2:0], 1'b0};
          r_q   <= step_r_c;
          q_q   <= {q_q[DATA_WIDTH-2:0], step_bit_c};
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(DATA_WIDTH - 1)) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          if (zero_q) begin
            quot_q <= '1;
            rem_q  <= num_q;
            dbz_q  <= 1'b1;
          end else begin
            quot_q <= neg_quot_q ? -q_q : q_q;
            rem_q  <= neg_rem_q  ? -r_q : r_q;
            dbz_q  <= 1'b0;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_busy        = busy_q;
  assign out_done        = done_q;
  assign out_quot        = quot_q;
  assign out_rem         = rem_q;
  assign out_div_by_zero = dbz_q;

endmodule
